// File: rtl/icache.sv
// Direct-mapped, one-word-per-frame instruction cache between a core's fetch
// stage and the bus controller instruction port. Hits complete combinationally.
module icache #(
    parameter int SETS = 16
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        imemREN,
    input  logic [31:0] imemaddr,
    output logic        ihit,
    output logic [31:0] imemload,
    output logic        iREN,
    output logic [31:0] iaddr,
    input  logic        iwait,
    input  logic [31:0] iload,
    output logic [31:0] miss_count
);

    localparam int IDXW = $clog2(SETS);
    localparam int TAGW = 30 - IDXW;

    typedef enum logic {
        LOOKUP = 1'b0,
        FILL   = 1'b1
    } state_e;

    state_e            state_q, state_d;
    logic [31:0]       miss_addr_q, miss_addr_d;
    logic [31:0]       miss_count_q, miss_count_d;
    logic [SETS-1:0]   valid_q;
    logic [TAGW-1:0]   tag_q  [SETS];
    logic [31:0]       data_q [SETS];

    logic [IDXW-1:0]   lookup_idx;
    logic [TAGW-1:0]   lookup_tag;
    logic              lookup_hit;
    logic [IDXW-1:0]   fill_idx;
    logic [TAGW-1:0]   fill_tag;
    logic              fill_we;

    // Byte-offset bits never take part in a lookup.
    logic              unused_offset;
    assign unused_offset = ^imemaddr[1:0];

    assign lookup_idx = imemaddr[IDXW+1:2];
    assign lookup_tag = imemaddr[31:IDXW+2];
    assign lookup_hit = imemREN && valid_q[lookup_idx] && (tag_q[lookup_idx] == lookup_tag);

    assign fill_idx   = miss_addr_q[IDXW+1:2];
    assign fill_tag   = miss_addr_q[31:IDXW+2];

    // NOTE: every signal driven here gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_d      = state_q;
        miss_addr_d  = miss_addr_q;
        miss_count_d = miss_count_q;
        fill_we      = 1'b0;
        ihit         = 1'b0;
        imemload     = 32'h0;
        iREN         = 1'b0;
        iaddr        = 32'h0;

        case (state_q)
            LOOKUP: begin
                ihit     = lookup_hit;
                imemload = lookup_hit ? data_q[lookup_idx] : 32'h0;
                if (imemREN && !lookup_hit) begin
                    miss_addr_d = {imemaddr[31:2], 2'b00};
                    state_d     = FILL;
                end
            end
            FILL: begin
                iREN  = 1'b1;
                iaddr = miss_addr_q;
                if (!iwait) begin
                    fill_we      = 1'b1;
                    miss_count_d = miss_count_q + 32'd1;
                    state_d      = LOOKUP;
                end
            end
            default: state_d = LOOKUP;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= LOOKUP;
            miss_addr_q  <= 32'h0;
            miss_count_q <= 32'h0;
            valid_q      <= '0;
        end else begin
            state_q      <= state_d;
            miss_addr_q  <= miss_addr_d;
            miss_count_q <= miss_count_d;
            if (fill_we) begin
                valid_q[fill_idx] <= 1'b1;
            end
        end
    end

    // NOTE: tag and data arrays are deliberately left out of reset; the valid
    // bits alone make stale contents unobservable. Reset still blocks the write.
    always_ff @(posedge CLK) begin
        if (fill_we && !RST) begin
            tag_q[fill_idx]  <= fill_tag;
            data_q[fill_idx] <= iload;
        end
    end

    assign miss_count = miss_count_q;

endmodule
